rhythm_recorder: RTL and testbench

- Capture-side counterpart to the rhythm playback datapath. The player taps the GPIO button and the block writes each tap into a MAP_LEN-bit rhythm map.
- Taps are quantised to the existing 8 Hz tick.
- The finished map uses the same bit ordering the playback shifter consumes, so replaying it puts every recorded note in the "perfect" judge bit at the moment it was tapped.
- Sits beside the playback datapath. Its map output can drive the playback init_rhythm_map input in place of the hard-coded map.

---
 rtl/rhythm_recorder_pkg.sv | 20 ++
 rtl/rhythm_recorder_key_sync_edge.sv | 28 ++
 rtl/rhythm_recorder.sv | 105 ++++++++++
 tb/tb_rhythm_recorder.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/rhythm_recorder_pkg.sv
// rtl/rhythm_recorder_pkg.sv - shared map geometry and recorder state encoding
package rhythm_recorder_pkg;

    // Map width and perfect-judge offset, shared with the playback datapath
    localparam int MAP_LEN = 191;
    localparam int LEAD    = 2;
    localparam int SLOT_W  = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RECORD = 2'd1,
        ST_DONE   = 2'd2
    } rec_state_t;

    // Note counter increment that sticks at 255
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/rhythm_recorder_key_sync_edge.sv
// rtl/rhythm_recorder_key_sync_edge.sv - 2-flop synchroniser with registered falling-edge pulse
module key_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic press
);

    logic sync_1;
    logic sync_2;
    logic last_lvl;

    // Synchronise the raw key and emit one pulse per 1->0 transition (pin to pulse = 3 clk)
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_1   <= 1'b1;
            sync_2   <= 1'b1;
            last_lvl <= 1'b1;
            press    <= 1'b0;
        end else begin
            sync_1   <= key_n;
            sync_2   <= sync_1;
            last_lvl <= sync_2;
            press    <= last_lvl & ~sync_2;
        end
    end

endmodule

// File: rtl/rhythm_recorder.sv
// rtl/rhythm_recorder.sv - records button taps into a playback-ordered rhythm map
module rhythm_recorder
    import rhythm_recorder_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                tick,
    input  logic                start_n,
    input  logic                button_n,
    output logic [MAP_LEN-1:0]  rec_map,
    output logic                map_valid,
    output logic                recording,
    output logic [7:0]          note_count,
    output logic [SLOT_W-1:0]   slot
);

    rec_state_t         state;
    rec_state_t         state_nxt;
    logic               start_ev;
    logic               tap_ev;
    logic [SLOT_W:0]    idx;
    logic               last_slot;
    logic [MAP_LEN-1:0] tap_mask;
    logic               tap_new;

    key_sync_edge u_start_key (
        .clk   (clk),
        .rst   (rst),
        .key_n (start_n),
        .press (start_ev)
    );

    key_sync_edge u_tap_key (
        .clk   (clk),
        .rst   (rst),
        .key_n (button_n),
        .press (tap_ev)
    );

    // Target bit for a tap in the current slot; one extra bit so slot+LEAD never wraps
    assign idx       = {1'b0, slot} + (SLOT_W+1)'(LEAD);
    assign last_slot = (idx == (SLOT_W+1)'(MAP_LEN - 1));
    assign tap_mask  = {{(MAP_LEN-1){1'b0}}, 1'b1} << idx;
    assign tap_new   = (tap_mask != '0) && ((rec_map & tap_mask) == '0);

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and status outputs; a stop request outranks a tick
    always_comb begin
        state_nxt = state;
        map_valid = 1'b0;
        recording = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start_ev) state_nxt = ST_RECORD;
            end
            ST_RECORD: begin
                recording = 1'b1;
                if (start_ev)              state_nxt = ST_DONE;
                else if (tick && last_slot) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                map_valid = 1'b1;
                if (start_ev) state_nxt = ST_RECORD;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Map, note counter and slot; taps use the pre-increment slot
    always_ff @(posedge clk) begin
        if (!rst) begin
            rec_map    <= '0;
            note_count <= 8'd0;
            slot       <= '0;
        end else begin
            case (state)
                ST_RECORD: begin
                    if (tap_ev && tap_new) begin
                        rec_map    <= rec_map | tap_mask;
                        note_count <= sat_inc8(note_count);
                    end
                    if (tick && !start_ev && !last_slot) begin
                        slot <= slot + SLOT_W'(1);
                    end
                end
                default: begin
                    if (start_ev) begin
                        rec_map    <= '0;
                        note_count <= 8'd0;
                        slot       <= '0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rhythm_recorder.sv
// tb/tb_rhythm_recorder.sv - scoreboard bench for rhythm_recorder
module tb_rhythm_recorder;

    localparam int ML = 191;
    localparam int LD = 2;
    localparam int SW = 8;

    logic          clk;
    logic          rst;
    logic          tick;
    logic          start_n;
    logic          button_n;
    logic [ML-1:0] rec_map;
    logic          map_valid;
    logic          recording;
    logic [7:0]    note_count;
    logic [SW-1:0] slot;

    int n_tests;
    int n_fail;

    logic [ML-1:0] m_map;
    int            m_count;
    int            m_slot;
    int            m_state;
    int            exp_q[$];
    logic [7:0]    prev_count;

    rhythm_recorder dut (
        .clk        (clk),
        .rst        (rst),
        .tick       (tick),
        .start_n    (start_n),
        .button_n   (button_n),
        .rec_map    (rec_map),
        .map_valid  (map_valid),
        .recording  (recording),
        .note_count (note_count),
        .slot       (slot)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_map = '0; m_count = 0; m_slot = 0; m_state = 0;
    endtask

    task automatic model_tap();
        int i;
        i = m_slot + LD;
        if (m_state == 1 && i < ML && !m_map[i]) begin
            m_map[i] = 1'b1;
            if (m_count < 255) m_count++;
            exp_q.push_back(i);
        end
    endtask

    task automatic model_start();
        if (m_state == 1) begin
            m_state = 2;
        end else begin
            m_map = '0; m_count = 0; m_slot = 0; m_state = 1;
        end
    endtask

    task automatic model_tick();
        if (m_state == 1) begin
            if (m_slot + LD == ML - 1) m_state = 2;
            else m_slot++;
        end
    endtask

    task automatic plain_tick();
        tick = 1'b1;
        step(1);
        tick = 1'b0;
        model_tick();
    endtask

    // Key press(es) whose event lands in the same clk as an optional tick
    task automatic ev(input bit do_start, input bit do_btn, input bit do_tick);
        if (do_start) start_n = 1'b0;
        if (do_btn)   button_n = 1'b0;
        step(3);
        tick = do_tick;
        step(1);
        tick = 1'b0;
        if (do_btn) model_tap();
        if (do_start) model_start();
        else if (do_tick) model_tick();
        start_n = 1'b1;
        button_n = 1'b1;
        step(4);
    endtask

    task automatic check_all(input string tag);
        check({tag, "_map"},   256'(rec_map),    256'(m_map));
        check({tag, "_count"}, 256'(note_count), 256'(m_count));
        check({tag, "_slot"},  256'(slot),       256'(m_slot));
        check({tag, "_rec"},   256'(recording),  256'(m_state == 1));
        check({tag, "_valid"}, 256'(map_valid),  256'(m_state == 2));
    endtask

    // Scoreboard: every observed note_count increment must match a queued expected write
    always @(negedge clk) begin
        if (rst && note_count > prev_count) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_write", 256'(note_count), 256'(prev_count));
            end else begin
                int i;
                i = exp_q.pop_front();
                check("sb_write_bit", 256'(rec_map[i]), 256'(1));
                check("sb_count_step", 256'(note_count), 256'(prev_count) + 256'(1));
            end
        end
        prev_count <= note_count;
    end

    initial begin
        n_tests = 0; n_fail = 0;
        prev_count = 8'd0;
        rst = 1'b0; tick = 1'b0; start_n = 1'b1; button_n = 1'b1;
        model_reset();
        step(3);
        rst = 1'b1;
        step(1);
        check_all("reset");

        ev(0, 1, 0);
        check_all("idle_tap_ignored");

        // Reset mid-record
        ev(1, 0, 0);
        ev(0, 1, 0); plain_tick();
        ev(0, 1, 0); plain_tick();
        ev(0, 1, 0);
        check_all("pre_reset");
        rst = 1'b0;
        step(1);
        rst = 1'b1;
        model_reset();
        step(1);
        check_all("reset_mid");

        // Basic capture
        ev(1, 0, 0);
        ev(0, 1, 0);
        for (int k = 0; k < 5; k++) plain_tick();
        ev(0, 1, 0);
        ev(1, 0, 0);
        check_all("basic");
        check("basic_bits", 256'(rec_map), 256'((1 << 2) | (1 << 7)));

        ev(0, 1, 0);
        check_all("done_tap_ignored");

        // Re-record from DONE
        ev(1, 0, 0);
        check_all("rerecord");

        // Double tap and held key in slot 3
        for (int k = 0; k < 3; k++) plain_tick();
        ev(0, 1, 0);
        ev(0, 1, 0);
        button_n = 1'b0;
        step(5);
        model_tap();
        for (int k = 0; k < 10; k++) begin
            plain_tick();
            step(2);
        end
        button_n = 1'b1;
        step(4);
        check_all("held");
        check("held_bits", 256'(rec_map), 256'(1 << 5));

        // Tap/tick coincidence at slot 9
        ev(1, 0, 0);
        ev(1, 0, 0);
        for (int k = 0; k < 9; k++) plain_tick();
        ev(0, 1, 1);
        check_all("tap_tick");
        check("tap_tick_bit11", 256'(rec_map[11]), 256'(1));

        // Start and tick together: stop wins, slot holds
        ev(1, 0, 1);
        check_all("stop_tick");

        // Start and tap together in RECORD
        ev(1, 0, 0);
        for (int k = 0; k < 4; k++) plain_tick();
        ev(1, 1, 0);
        check_all("stop_tap");

        // Full map: tap on the finishing tick
        ev(1, 0, 0);
        for (int k = 0; k < 188; k++) plain_tick();
        check_all("full_pre");
        ev(0, 1, 1);
        check_all("full_done");
        check("full_bit190", 256'(rec_map[190]), 256'(1));
        ev(0, 1, 0);
        plain_tick();
        check_all("full_after");

        step(4);
        check("sb_empty", 256'(exp_q.size()), 256'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
